// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter: moves one packet at a time from a source FIFO head to its destination terminal(s).
// Latency: fixed 3 cycles per packet (IDLE arbitrate, POP dequeue/capture, PUSH deliver); one transfer in flight.
// Backpressure: none on the push side; sources are throttled only by arbitration and the fixed 3-cycle period.
module bus_rr_arbiter #(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
    output logic                            busy,
    output logic                            err
);

    localparam int gw = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    state_t             state;
    logic [gw-1:0]      grant;
    logic [gw-1:0]      last_grant;
    logic [gw-1:0]      next_grant;
    logic               any_req;
    logic [drvrs-1:0]   pop_nxt;
    logic [pckg_sz-1:0] pkt;
    logic [7:0]         dest;
    logic [drvrs-1:0]   push_nxt;
    logic               err_nxt;
    int                 idx;

    // Round-robin search: first pending terminal after last_grant, wrapping at drvrs.
    always_comb begin
        next_grant = last_grant;
        any_req    = 1'b0;
        idx        = 0;
        for (int k = 1; k <= drvrs; k++) begin
            idx = (int'(last_grant) + k) % drvrs;
            if (!any_req && pndng[idx]) begin
                any_req    = 1'b1;
                next_grant = gw'(idx);
            end
        end
        pop_nxt = '0;
        for (int i = 0; i < drvrs; i++) begin
            pop_nxt[i] = (i == int'(next_grant));
        end
    end

    // Destination is the top byte of the head packet of the granted terminal.
    assign dest = D_pop[grant][pckg_sz-1 -: 8];

    // Delivery decode: broadcast fans out to everyone but the source; self or out-of-range IDs are dropped with err.
    always_comb begin
        push_nxt = '0;
        err_nxt  = 1'b0;
        if (dest == broadcast) begin
            for (int i = 0; i < drvrs; i++) begin
                push_nxt[i] = (i != int'(grant));
            end
        end else if ((int'(dest) < drvrs) && (dest != 8'(grant))) begin
            for (int i = 0; i < drvrs; i++) begin
                push_nxt[i] = (int'(dest) == i);
            end
        end else begin
            err_nxt = 1'b1;
        end
    end

    // Transfer FSM with registered strobes; reset aborts any transfer in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= gw'(drvrs - 1);
            pkt        <= '0;
            pop        <= '0;
            push       <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    push <= '0;
                    err  <= 1'b0;
                    if (any_req) begin
                        grant <= next_grant;
                        pop   <= pop_nxt;
                        busy  <= 1'b1;
                        state <= POP;
                    end else begin
                        pop  <= '0;
                        busy <= 1'b0;
                    end
                end
                POP: begin
                    pop        <= '0;
                    pkt        <= D_pop[grant];
                    last_grant <= grant;
                    push       <= push_nxt;
                    err        <= err_nxt;
                    state      <= PUSH;
                end
                PUSH: begin
                    push  <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    pop   <= '0;
                    push  <= '0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Every terminal sees the last captured packet; push selects who actually takes it.
    always_comb begin
        for (int i = 0; i < drvrs; i++) begin
            D_push[i] = pkt;
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter (drvrs=4, pckg_sz=16).
// Source FIFOs are modelled per terminal; expected transfers are queued at stimulus time.
// A negedge monitor pops expectations on each pop strobe and checks the following push cycle.
module tb_bus_rr_arbiter;

    logic             clk;
    logic             reset;
    logic [3:0]       pndng;
    logic [3:0][15:0] D_pop;
    logic [3:0]       pop;
    logic [3:0]       push;
    logic [3:0][15:0] D_push;
    logic             busy;
    logic             err;

    bus_rr_arbiter #(
        .drvrs     (4),
        .pckg_sz   (16),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (D_pop),
        .pop    (pop),
        .push   (push),
        .D_push (D_push),
        .busy   (busy),
        .err    (err)
    );

    typedef struct {
        int          src;
        logic [15:0] pkt;
        logic [3:0]  push;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          pop_times[$];
    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    bit          in_push = 0;
    logic [3:0]  last_pop = '0;
    logic [15:0] last_pkt = '0;
    logic [15:0] fmem [4][8];
    int          fhead [4];
    int          fcnt  [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic exp_t mk(input int src, input logic [15:0] p);
        exp_t e;
        logic [7:0] d;
        d      = p[15:8];
        e.src  = src;
        e.pkt  = p;
        e.push = 4'h0;
        e.err  = 1'b0;
        if (d == 8'hFF)
            e.push = 4'hF & ~(4'b0001 << src);
        else if (d < 8'd4 && int'(d) != src)
            e.push = 4'b0001 << d;
        else
            e.err = 1'b1;
        return e;
    endfunction

    task automatic sb_add(input int src, input logic [15:0] p);
        sb.push_back(mk(src, p));
    endtask

    task automatic enq(input int term, input logic [15:0] p);
        fmem[term][(fhead[term] + fcnt[term]) % 8] = p;
        fcnt[term]++;
    endtask

    task automatic fifo_clear();
        for (int i = 0; i < 4; i++) begin
            fhead[i] = 0;
            fcnt[i]  = 0;
        end
        pndng = '0;
        D_pop = '0;
    endtask

    // FIFO model: dequeue after each pop strobe, then present head and non-empty flag.
    initial begin
        fifo_clear();
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                for (int i = 0; i < 4; i++) begin
                    if (last_pop[i] && fcnt[i] > 0) begin
                        fhead[i] = (fhead[i] + 1) % 8;
                        fcnt[i]--;
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                pndng[i] = (fcnt[i] != 0);
                D_pop[i] = (fcnt[i] != 0) ? fmem[i][fhead[i]] : 16'h0000;
            end
        end
    end

    // Monitor: pop cycle consumes an expectation, the next cycle must deliver it.
    always @(negedge clk) begin
        last_pop = pop;
        if (reset) begin
            in_push  = 1'b0;
            last_pkt = '0;
        end else if (in_push) begin
            chk("push_mask", push, cur.push);
            chk("err_pulse", err, cur.err);
            chk("busy_push", busy, 1);
            chk("pop_in_push", pop, 0);
            for (int i = 0; i < 4; i++) chk("d_push", D_push[i], cur.pkt);
            last_pkt = cur.pkt;
            in_push  = 1'b0;
        end else begin
            chk("push_idle", push, 0);
            chk("err_idle", err, 0);
            chk("d_push_hold", D_push[0], last_pkt);
            if (pop != 0) begin
                chk("pop_onehot", $countones(pop), 1);
                chk("busy_pop", busy, 1);
                pop_times.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_pop", pop, 0);
                end else begin
                    cur = sb.pop_front();
                    chk("pop_grant", pop, 4'b0001 << cur.src);
                    in_push = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        fifo_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop", pop, 0);
        chk("rst_push", push, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_d_push", D_push, 0);
        reset = 1'b0;
        pop_times.delete();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || in_push) && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    task automatic wait_pop(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (pop != 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("pop_seen", ok, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset = 1'b1;

        // Single unicast transfer 0 -> 2.
        do_reset();
        enq(0, 16'h02AB);
        sb_add(0, 16'h02AB);
        drain("drain_unicast");

        // All terminals pending: grants 0,1,2,3,0 every 3 cycles.
        do_reset();
        enq(0, 16'h01A0);
        enq(1, 16'h02B1);
        enq(2, 16'h03C2);
        enq(3, 16'h00D3);
        enq(0, 16'hFF0E);
        sb_add(0, 16'h01A0);
        sb_add(1, 16'h02B1);
        sb_add(2, 16'h03C2);
        sb_add(3, 16'h00D3);
        sb_add(0, 16'hFF0E);
        drain("drain_rr");
        chk("rr_pop_count", pop_times.size(), 5);
        for (int i = 1; i < pop_times.size(); i++)
            chk("rr_spacing", pop_times[i] - pop_times[i-1], 3);

        // Broadcast from terminal 1.
        do_reset();
        enq(1, 16'hFF55);
        sb_add(1, 16'hFF55);
        drain("drain_bcast");

        // Invalid destination, then destination equal to source.
        do_reset();
        enq(3, 16'h0711);
        enq(3, 16'h0322);
        sb_add(3, 16'h0711);
        sb_add(3, 16'h0322);
        drain("drain_err");

        // Reset during POP aborts; next search restarts at terminal 0.
        do_reset();
        enq(1, 16'h0011);
        sb_add(1, 16'h0011);
        drain("drain_pre_abort");
        enq(2, 16'h0122);
        sb_add(2, 16'h0122);
        wait_pop(ok);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_pop", pop, 0);
        chk("abort_push", push, 0);
        chk("abort_busy", busy, 0);
        sb.delete();
        fifo_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        enq(0, 16'h0300);
        enq(3, 16'h0133);
        sb_add(0, 16'h0300);
        sb_add(3, 16'h0133);
        drain("drain_post_abort");

        // pndng drops during POP: transfer still completes, then idle.
        do_reset();
        enq(2, 16'h00EE);
        sb_add(2, 16'h00EE);
        wait_pop(ok);
        #1;
        pndng = '0;
        drain("drain_drop");
        repeat (8) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_pop_count", pop_times.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
